// File: rtl/sync_fifo_prog_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog_pkg
// Shared definitions for the programmable synchronous FIFO:
//   - default widths and threshold helpers
//   - depth derivation from the address width
//   - binary-to-Gray conversion used for the exported pointers
//   - the per-cycle transfer decision struct
// -----------------------------------------------------------------------------
package sync_fifo_prog_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;

    // Number of storage entries for a given address width.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Reasonable power-on threshold choices for a given address width:
    // almost-full two entries short of full, almost-empty at one entry.
    function automatic int def_afull_th(input int aw);
        return depth_of(aw) - 2;
    endfunction

    function automatic int def_aempty_th(input int aw);
        return (aw > 0) ? 1 : 0;
    endfunction

    // Gray code of a binary value. Operates on a wide word; callers cast
    // the result down to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Which side of the FIFO actually moves this cycle.
    typedef struct packed {
        logic wr;
        logic rd;
    } xfer_t;

endpackage

// File: rtl/sync_fifo_prog_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog_if
// Bundles every non-clock/reset signal of the programmable FIFO.
//   producer side : w_inc, w_data, wfull, afull, ovf, wptr
//   consumer side : r_inc, r_data, r_valid, rempty, aempty, udf, rptr
//   control       : afull_th, aempty_th, err_clr, level
// modport master : the user of the FIFO (drives requests and thresholds)
// modport slave  : the FIFO itself
//
// Handshake: a write moves on a rising clk edge when w_inc is high and wfull
// was low before that edge; a read moves when r_inc is high and rempty was
// low before that edge. A request made against a full/empty FIFO is dropped
// and sets the sticky ovf/udf flag. Read data appears one cycle after the
// accepted read, qualified by r_valid for exactly that cycle.
// -----------------------------------------------------------------------------
interface sync_fifo_prog_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    localparam int PW = ADDR_WIDTH + 1;

    logic                  w_inc;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_inc;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  wfull;
    logic                  rempty;
    logic [PW-1:0]         afull_th;
    logic [PW-1:0]         aempty_th;
    logic                  afull;
    logic                  aempty;
    logic [PW-1:0]         level;
    logic                  ovf;
    logic                  udf;
    logic                  err_clr;
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;

    modport master (
        output w_inc, w_data, r_inc, afull_th, aempty_th, err_clr,
        input  r_data, r_valid, wfull, rempty, afull, aempty, level,
               ovf, udf, wptr, rptr
    );

    modport slave (
        input  w_inc, w_data, r_inc, afull_th, aempty_th, err_clr,
        output r_data, r_valid, wfull, rempty, afull, aempty, level,
               ovf, udf, wptr, rptr
    );

endinterface

// File: rtl/sync_fifo_prog_dpram.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog_dpram
// DEPTH x DATA_WIDTH storage with one synchronous write port and one
// synchronous read port. No reset: contents and the read register power up
// undefined; the FIFO top masks o_rdata until the first real read.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data
//   i_re     in   read enable (o_rdata holds when low)
//   i_raddr  in   read address
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module sync_fifo_prog_dpram
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// an occupancy output, sticky overflow/underflow flags and Gray-coded
// pointer outputs compatible with async FIFO pointer logic.
// Ports:
//   clk   in   clock, everything on posedge
//   rst   in   asynchronous active-high reset
//   bus   slave modport of sync_fifo_prog_if (requests, data, flags,
//         thresholds, level, error flags, Gray pointers)
// -----------------------------------------------------------------------------
module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_prog_if.slave       bus
);
    localparam int            DEPTH   = depth_of(ADDR_WIDTH);
    localparam int            PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_L = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_L   = PW'(1);

    // Binary pointers carry one extra wrap bit above the memory address.
    logic [PW-1:0]         r_wbin;
    logic [PW-1:0]         r_rbin;
    logic [PW-1:0]         r_level;
    logic                  r_valid_q;
    logic                  r_has_data;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_full;
    logic                  w_empty;
    xfer_t                 w_xfer;
    logic [DATA_WIDTH-1:0] w_mem_q;

    assign w_full  = (r_level == DEPTH_L);
    assign w_empty = (r_level == '0);

    // Flags come from the pre-edge level, so at full only the read moves
    // and at empty only the write moves.
    assign w_xfer.wr = bus.w_inc && !w_full;
    assign w_xfer.rd = bus.r_inc && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbin     <= '0;
            r_rbin     <= '0;
            r_level    <= '0;
            r_valid_q  <= 1'b0;
            r_has_data <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            if (w_xfer.wr) begin
                r_wbin <= r_wbin + ONE_L;
            end
            if (w_xfer.rd) begin
                r_rbin <= r_rbin + ONE_L;
            end

            case ({w_xfer.wr, w_xfer.rd})
                2'b10:   r_level <= r_level + ONE_L;
                2'b01:   r_level <= r_level - ONE_L;
                default: r_level <= r_level;
            endcase

            r_valid_q <= w_xfer.rd;
            if (w_xfer.rd) begin
                r_has_data <= 1'b1;
            end

            // A new error in the same cycle as err_clr must not be lost.
            if (bus.w_inc && w_full) begin
                r_ovf <= 1'b1;
            end else if (bus.err_clr) begin
                r_ovf <= 1'b0;
            end

            if (bus.r_inc && w_empty) begin
                r_udf <= 1'b1;
            end else if (bus.err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    sync_fifo_prog_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_xfer.wr),
        .i_waddr (r_wbin[ADDR_WIDTH-1:0]),
        .i_wdata (bus.w_data),
        .i_re    (w_xfer.rd),
        .i_raddr (r_rbin[ADDR_WIDTH-1:0]),
        .o_rdata (w_mem_q)
    );

    // The RAM read register has no reset; present zero until the first
    // read after reset so r_data has a defined reset value.
    assign bus.r_data  = r_has_data ? w_mem_q : '0;
    assign bus.r_valid = r_valid_q;

    assign bus.wfull  = w_full;
    assign bus.rempty = w_empty;
    // A threshold above DEPTH can never be reached, so afull stays low.
    assign bus.afull  = (r_level >= bus.afull_th);
    assign bus.aempty = (r_level <= bus.aempty_th);
    assign bus.level  = r_level;
    assign bus.ovf    = r_ovf;
    assign bus.udf    = r_udf;

    assign bus.wptr = PW'(bin2gray(32'(r_wbin)));
    assign bus.rptr = PW'(bin2gray(32'(r_rbin)));

endmodule
